// File: rtl/window_fetch_sequencer.sv
// Window fetch sequencer: walks the window origin across the frame and, for
// each origin, fetches the 32 generator addresses and streams the words out.
// Ports:
//   clk, rst (async, active-high), start -> busy, done
//   cur_addr/addr_sel -> window generator, gen_addr <- generator output
//   mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata : one-word read port
//   out_valid/out_ready/out_data/out_idx/out_last : downstream stream
//   pos_row/pos_col : current window position
// Optional: define WFS_STALL_CNT_EN to add stall_cnt (REQ/PUSH stall cycles).
module window_fetch_sequencer #(
    parameter int FRAME_COLS = 64,
    parameter int FRAME_ROWS = 64,
    parameter int WIN_COLS   = 12,
    parameter int WIN_ROWS   = 4,
    parameter int COL_STEP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] cur_addr,
    output logic [4:0]  addr_sel,
    input  logic [31:0] gen_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic [15:0] pos_row,
    output logic [15:0] pos_col
`ifdef WFS_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_ADV,
        S_FIN
    } state_t;

    localparam int COL_MAX = FRAME_COLS - WIN_COLS;
    localparam int ROW_MAX = FRAME_ROWS - WIN_ROWS;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_row;
    logic [15:0] r_col;
    logic [4:0]  r_sel;
    logic [31:0] r_mem_addr;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_idx;
    logic        r_out_last;

    logic [31:0] w_col_sum;
    logic [31:0] w_row_sum;
    logic        w_col_wrap;
    logic        w_scan_end;
    logic        w_start_ok;
    logic        w_sel_last;

    assign w_col_sum  = {16'd0, r_col} + 32'(COL_STEP);
    assign w_row_sum  = {16'd0, r_row} + 32'd1;
    assign w_col_wrap = w_col_sum > 32'(COL_MAX);
    // Last position: keep row/col so cur_addr still shows it after done.
    assign w_scan_end = w_col_wrap && (w_row_sum > 32'(ROW_MAX));
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_sel_last = (r_sel == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_req     = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                busy        = 1'b1;
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) w_state_nxt = S_PUSH;
            end
            S_PUSH: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = w_sel_last ? S_ADV : S_LAUNCH;
                end
            end
            S_ADV: begin
                busy        = 1'b1;
                w_state_nxt = w_scan_end ? S_FIN : S_LAUNCH;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_sel      <= '0;
            r_mem_addr <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_row <= '0;
                r_col <= '0;
                r_sel <= '0;
            end
            if (r_state == S_LAUNCH) begin
                r_mem_addr <= gen_addr;
            end
            if ((r_state == S_WAIT) && mem_rvalid) begin
                r_out_data <= mem_rdata;
                r_out_idx  <= r_sel;
                r_out_last <= w_sel_last;
            end
            if ((r_state == S_PUSH) && out_ready && !w_sel_last) begin
                r_sel <= r_sel + 5'd1;
            end
            if (r_state == S_ADV) begin
                r_sel <= '0;
                if (!w_scan_end) begin
                    if (w_col_wrap) begin
                        r_col <= '0;
                        r_row <= w_row_sum[15:0];
                    end else begin
                        r_col <= w_col_sum[15:0];
                    end
                end
            end
        end
    end

`ifdef WFS_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_REQ) && !mem_gnt) ||
                     ((r_state == S_PUSH) && !out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign cur_addr  = 32'(r_row) * 32'(FRAME_COLS) + 32'(r_col);
    assign addr_sel  = r_sel;
    assign mem_addr  = r_mem_addr;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign pos_row   = r_row;
    assign pos_col   = r_col;

endmodule

// File: tb/tb_window_fetch_sequencer.sv
// Directed bench for window_fetch_sequencer: default-size instance for
// word order/stalls/wrap/reset, small-frame instance for a full scan.
module tb_window_fetch_sequencer;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mem_gnt, mem_rvalid, out_ready;
    logic        busy, done, mem_req, out_valid, out_last;
    logic [31:0] cur_addr, gen_addr, mem_addr, mem_rdata, out_data;
    logic [4:0]  addr_sel, out_idx;
    logic [15:0] pos_row, pos_col;

    logic        s_rst, s_start, s_busy, s_done, s_req, s_valid, s_last;
    logic [31:0] s_cur, s_gen, s_maddr, s_rdata, s_data;
    logic [4:0]  s_sel, s_idx;
    logic [15:0] s_row, s_col;
    logic        s_one;

`ifdef WFS_STALL_CNT_EN
    logic [31:0] stall_cnt, s_stall;
`endif

    int n_chk = 0;
    int n_err = 0;
    int n_gnt = 0;
    int n_done = 0;
    int n_shs = 0;
    int n_sdone = 0;

    function automatic logic [31:0] gen(input logic [31:0] base,
                                        input logic [4:0] sel,
                                        input int cols);
        return 32'd16 + 32'd4 * (base + 32'(sel >> 3) * 32'(cols)
                                 + 32'd4 + 32'(sel & 5'd7));
    endfunction

    assign gen_addr  = gen(cur_addr, addr_sel, 64);
    assign mem_rdata = mem_addr ^ K;
    assign s_gen     = gen(s_cur, s_sel, 16);
    assign s_rdata   = s_maddr;

    window_fetch_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cur_addr(cur_addr), .addr_sel(addr_sel), .gen_addr(gen_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .pos_row(pos_row), .pos_col(pos_col)
`ifdef WFS_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    window_fetch_sequencer #(
        .FRAME_COLS(16), .FRAME_ROWS(6), .WIN_COLS(12), .WIN_ROWS(4),
        .COL_STEP(1)
    ) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy),
        .done(s_done), .cur_addr(s_cur), .addr_sel(s_sel),
        .gen_addr(s_gen), .mem_req(s_req), .mem_addr(s_maddr),
        .mem_gnt(s_one), .mem_rvalid(s_one), .mem_rdata(s_rdata),
        .out_valid(s_valid), .out_ready(s_one), .out_data(s_data),
        .out_idx(s_idx), .out_last(s_last),
        .pos_row(s_row), .pos_col(s_col)
`ifdef WFS_STALL_CNT_EN
        , .stall_cnt(s_stall)
`endif
    );

    always @(posedge clk) begin
        if (!rst && mem_req && mem_gnt) n_gnt <= n_gnt + 1;
        if (!rst && done) n_done <= n_done + 1;
        if (!s_rst && s_valid && s_one) n_shs <= n_shs + 1;
        if (!s_rst && s_done) n_sdone <= n_sdone + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic finish_tb();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    endtask

    // what: 0 out handshake, 1 out_valid, 2 mem_req, 3 mem_req&gnt
    task automatic wait_for(input int what, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            case (what)
                0:       hit = out_valid && out_ready;
                1:       hit = out_valid;
                2:       hit = mem_req;
                default: hit = mem_req && mem_gnt;
            endcase
            if (hit) break;
        end
        if (!hit) begin
            check($sformatf("timeout_wait%0d", what), 32'(hit), 32'd1);
            finish_tb();
        end
    endtask

    task automatic run_pos(input logic [31:0] base, input bit tmg,
                           output logic [31:0] a0, output logic [31:0] a31);
        int c;
        a0  = '0;
        a31 = '0;
        for (int k = 0; k < 32; k++) begin
            wait_for(0, c);
            if (k == 0) begin
                check("pos_base", cur_addr, base);
                a0 = mem_addr;
            end
            if (k == 31) a31 = mem_addr;
            if (tmg && k > 0) check("word_cycles", 32'(c), 32'd4);
            check("idx", 32'(out_idx), 32'(k));
            check("last", 32'(out_last), 32'(k == 31));
            check("maddr", mem_addr, gen(base, 5'(k), 64));
            check("data", out_data, gen(base, 5'(k), 64) ^ K);
        end
    endtask

    initial begin
        int c;
        int g0;
        logic [31:0] a0, a31, d;

        rst = 1'b1; start = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_one = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cur", cur_addr, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        mem_gnt = 1'b1; mem_rvalid = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        run_pos(32'd0, 1'b1, a0, a31);
        check("addr_idx0", a0, 32'd32);
        check("addr_idx31", a31, 32'd828);

        // gnt held low for 5 REQ cycles on position (0,1) word 0
        mem_gnt = 1'b0;
        wait_for(2, c);
        check("adv_cur", cur_addr, 32'd1);
        check("adv_col", 32'(pos_col), 32'd1);
        g0 = n_gnt;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_maddr", mem_addr, 32'd36);
            @(negedge clk);
        end
        check("stall_req_end", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        wait_for(0, c);
        check("stall_idx", 32'(out_idx), 32'd0);
        check("stall_data", out_data, 32'd36 ^ K);
        check("one_read", 32'(n_gnt - g0), 32'd1);
`ifdef WFS_STALL_CNT_EN
        check("stall_cnt5", stall_cnt, 32'd5);
`endif
        for (int k = 1; k < 7; k++) begin
            wait_for(0, c);
            check("p1_idx", 32'(out_idx), 32'(k));
        end

        // out_ready low for 3 cycles while idx 7 is presented
        @(negedge clk);
        out_ready = 1'b0;
        wait_for(1, c);
        check("rdy_idx", 32'(out_idx), 32'd7);
        d = out_data;
        check("rdy_data", d, 32'd64 ^ K);
        g0 = n_gnt;
        for (int i = 0; i < 3; i++) begin
            check("rdy_valid", 32'(out_valid), 32'd1);
            check("rdy_hold", out_data, d);
            check("rdy_idx_hold", 32'(out_idx), 32'd7);
            check("rdy_noreq", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        check("rdy_nognt", 32'(n_gnt - g0), 32'd0);
        out_ready = 1'b1;
        check("rdy_valid_end", 32'(out_valid), 32'd1);
        for (int k = 8; k < 32; k++) begin
            wait_for(0, c);
            check("p1_idx", 32'(out_idx), 32'(k));
        end
`ifdef WFS_STALL_CNT_EN
        check("stall_cnt8", stall_cnt, 32'd8);
`endif

        // rest of row 0, with an ignored start pulse mid-scan
        for (int col = 2; col <= 52; col++) begin
            if (col == 10) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            run_pos(32'(col), 1'b0, a0, a31);
        end
        @(negedge clk);
        @(negedge clk);
        check("wrap_cur", cur_addr, 32'd64);
        check("wrap_row", 32'(pos_row), 32'd1);
        check("wrap_col", 32'(pos_col), 32'd0);
        check("wrap_busy", 32'(busy), 32'd1);

        for (int col = 0; col <= 52; col++)
            run_pos(32'd64 + 32'(col), 1'b0, a0, a31);
        for (int col = 0; col < 5; col++)
            run_pos(32'd128 + 32'(col), 1'b0, a0, a31);

        // position (2,5): reset while parked in WAIT on word 3
        for (int k = 0; k < 3; k++) begin
            wait_for(0, c);
            check("p25_idx", 32'(out_idx), 32'(k));
        end
        check("p25_cur", cur_addr, 32'd133);
        @(negedge clk);
        mem_rvalid = 1'b0;
        wait_for(3, c);
        @(negedge clk);
        check("wait_maddr", mem_addr, gen(32'd133, 5'd3, 64));
        check("wait_noreq", 32'(mem_req), 32'd0);
        rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_req", 32'(mem_req), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_cur", cur_addr, 32'd0);
        check("ar_maddr", mem_addr, 32'd0);
        check("ar_data", out_data, 32'd0);
        check("ar_idx", 32'(out_idx), 32'd0);
        check("ar_row", 32'(pos_row), 32'd0);
        check("ar_col", 32'(pos_col), 32'd0);
`ifdef WFS_STALL_CNT_EN
        check("ar_stall", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_pos(32'd0, 1'b1, a0, a31);
        check("restart_a0", a0, 32'd32);
        check("no_done_main", 32'(n_done), 32'd0);

        // full scan on the 16x6 frame: 5 cols x 3 rows x 32 words
        s_rst = 1'b0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (n_sdone > 0) break;
        end
        check("scan_done_seen", 32'(n_sdone), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("scan_words", 32'(n_shs), 32'd480);
        check("scan_done_once", 32'(n_sdone), 32'd1);
        check("scan_busy", 32'(s_busy), 32'd0);
        check("scan_cur", s_cur, 32'd36);
        check("scan_row", 32'(s_row), 32'd2);
        check("scan_col", 32'(s_col), 32'd4);
`ifdef WFS_STALL_CNT_EN
        check("scan_stall", s_stall, 32'd0);
`endif
        finish_tb();
    end

endmodule
